shift_fifo: RTL and testbench

- Parametrised successor to the push-driven register chain: a clocked, DEPTH-stage shift buffer with occupancy tracking.
- Words enter at stage 0 and shift toward stage DEPTH-1; the oldest valid word is popped from stage count-1.
- All taps and a per-stage valid mask are exported for parallel consumers such as correlators and window logic.
- It sits between a streaming producer and both a FIFO-style consumer and a parallel-tap consumer.

---
 rtl/shift_fifo_pkg.sv | 21 ++
 rtl/shift_fifo_stage.sv | 27 ++
 rtl/shift_fifo.sv | 175 +++++++++++++++++
 tb/tb_shift_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_fifo_pkg.sv
// Shared types and helpers for the shift_fifo buffer.
package shift_fifo_pkg;

  // Width needed to hold an occupancy value of 0..depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Qualified operation seen on a clock edge, drives the count update.
  typedef enum logic [1:0] {
    OP_IDLE    = 2'd0,
    OP_PUSH    = 2'd1,
    OP_POP     = 2'd2,
    OP_PUSHPOP = 2'd3
  } op_e;

  // Bit positions inside the sticky error vector.
  localparam int ERR_OVF = 1;
  localparam int ERR_UNF = 0;

endpackage

// File: rtl/shift_fifo_stage.sv
// One WIDTH-bit storage stage of the shift chain: async reset, load enable.
module shift_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_r;

  // Stage register: loads d_i when enabled, otherwise holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_r <= '0;
    end else if (en_i) begin
      q_r <= d_i;
    end else begin
      q_r <= q_r;
    end
  end

  assign q_o = q_r;

endmodule

// File: rtl/shift_fifo.sv
// DEPTH-stage shift buffer with occupancy tracking and parallel taps.
// Words enter at stage 0 and shift toward DEPTH-1; the oldest valid word
// sits at stage count-1. Pops only decrement the count.
// Optional: define SHIFT_FIFO_STICKY_ERR_EN to add sticky overflow/underflow
// flags (err_o) with their clear input (err_clr_i).
module shift_fifo
  import shift_fifo_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            pop_data_o,
  output logic [DEPTH-1:0][WIDTH-1:0] data_o,
  output logic [DEPTH-1:0]            valid_o,
  output logic [CNT_W-1:0]            count_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic                        overflow_o,
  output logic                        underflow_o
`ifdef SHIFT_FIFO_STICKY_ERR_EN
  ,
  input  logic                        err_clr_i,
  output logic [1:0]                  err_o
`endif
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [DEPTH-1:0][WIDTH-1:0] stage_s;
  logic [CNT_W-1:0]            count_r;
  logic [CNT_W-1:0]            count_nxt_s;
  logic                        shift_s;
  logic                        pop_ok_s;
  logic                        empty_s;
  logic                        full_s;
  logic                        ovf_nxt_s;
  logic                        unf_nxt_s;
  logic                        ovf_r;
  logic                        unf_r;
  logic [WIDTH-1:0]            pop_data_s;
  logic [DEPTH-1:0]            valid_s;
  op_e                         op_s;

  assign empty_s  = (count_r == '0);
  assign full_s   = (count_r == DEPTH_C);
  // clear_i masks both push and pop; a pop only counts when something is stored.
  assign shift_s  = push_i & ~clear_i;
  assign pop_ok_s = pop_i & ~clear_i & ~empty_s;

  // Storage chain: every stage loads its predecessor on a push.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (shift_s),
        .d_i   (data_i),
        .q_o   (stage_s[k])
      );
    end else begin : g_body
      shift_stage #(.WIDTH(WIDTH)) u_stage (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (shift_s),
        .d_i   (stage_s[k-1]),
        .q_o   (stage_s[k])
      );
    end
  end

  // Classify the qualified operation for this edge.
  always_comb begin
    op_s = OP_IDLE;
    case ({shift_s, pop_ok_s})
      2'b10:   op_s = OP_PUSH;
      2'b01:   op_s = OP_POP;
      2'b11:   op_s = OP_PUSHPOP;
      default: op_s = OP_IDLE;
    endcase
  end

  // Next occupancy, error pulse conditions; clear wins over everything.
  always_comb begin
    count_nxt_s = count_r;
    ovf_nxt_s   = 1'b0;
    unf_nxt_s   = 1'b0;
    if (clear_i) begin
      count_nxt_s = '0;
    end else begin
      case (op_s)
        OP_PUSH: begin
          if (full_s) begin
            count_nxt_s = count_r;
            ovf_nxt_s   = 1'b1;
          end else begin
            count_nxt_s = count_r + ONE_C;
          end
        end
        OP_POP:     count_nxt_s = count_r - ONE_C;
        OP_PUSHPOP: count_nxt_s = count_r;
        OP_IDLE:    count_nxt_s = count_r;
        default:    count_nxt_s = count_r;
      endcase
      // A pop on empty alone is an underflow; with a push it is simply ignored.
      unf_nxt_s = pop_i & ~push_i & empty_s;
    end
  end

  // Occupancy counter and registered one-cycle error pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= '0;
      ovf_r   <= 1'b0;
      unf_r   <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      ovf_r   <= ovf_nxt_s;
      unf_r   <= unf_nxt_s;
    end
  end

  // Pop mux: the stage at count-1, zero when nothing is stored.
  always_comb begin
    pop_data_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (count_r == CNT_W'(k + 1)) begin
        pop_data_s = stage_s[k];
      end else begin
        pop_data_s = pop_data_s;
      end
    end
  end

  // Thermometer decode of the count into the per-stage valid mask.
  always_comb begin
    valid_s = '0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_s[k] = (CNT_W'(k) < count_r);
    end
  end

`ifdef SHIFT_FIFO_STICKY_ERR_EN
  logic [1:0] err_r;

  // Sticky flags: set by the same condition that fires the pulse; set beats clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_r <= 2'b00;
    end else begin
      err_r[ERR_OVF] <= ovf_nxt_s | (err_r[ERR_OVF] & ~err_clr_i);
      err_r[ERR_UNF] <= unf_nxt_s | (err_r[ERR_UNF] & ~err_clr_i);
    end
  end

  assign err_o = err_r;
`endif

  assign pop_data_o  = pop_data_s;
  assign data_o      = stage_s;
  assign valid_o     = valid_s;
  assign count_o     = count_r;
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign overflow_o  = ovf_r;
  assign underflow_o = unf_r;

endmodule

// File: tb/tb_shift_fifo.sv
// Randomised and directed bench for shift_fifo against a queue-style model.
module tb_shift_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                        clk_i = 1'b0;
  logic                        rst_i = 1'b1;
  logic                        clear_i = 1'b0;
  logic                        push_i = 1'b0;
  logic [WIDTH-1:0]            data_i = '0;
  logic                        pop_i = 1'b0;
  logic [WIDTH-1:0]            pop_data_o;
  logic [DEPTH-1:0][WIDTH-1:0] data_o;
  logic [DEPTH-1:0]            valid_o;
  logic [CNT_W-1:0]            count_o;
  logic                        empty_o;
  logic                        full_o;
  logic                        overflow_o;
  logic                        underflow_o;
  logic                        err_clr_i = 1'b0;
`ifdef SHIFT_FIFO_STICKY_ERR_EN
  logic [1:0]                  err_o;
`endif

  shift_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .push_i      (push_i),
    .data_i      (data_i),
    .pop_i       (pop_i),
    .pop_data_o  (pop_data_o),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .count_o     (count_o),
    .empty_o     (empty_o),
    .full_o      (full_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
`ifdef SHIFT_FIFO_STICKY_ERR_EN
    ,
    .err_clr_i   (err_clr_i),
    .err_o       (err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: stage contents, occupancy, last-edge pulses, sticky flags.
  logic [WIDTH-1:0] m_stage [DEPTH];
  int               m_cnt;
  bit               m_ovf, m_unf;
  bit   [1:0]       m_err;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) m_stage[k] = '0;
    m_cnt = 0; m_ovf = 0; m_unf = 0; m_err = 2'b00;
  endtask

  // Apply one clock edge's worth of behaviour to the model.
  task automatic model_edge(input bit p, input bit q, input bit c, input logic [WIDTH-1:0] d, input bit ec);
    int  pre;
    bit  qq;
    pre = m_cnt;
    m_ovf = 0; m_unf = 0;
    if (c) begin
      m_cnt = 0;
    end else begin
      qq = q && (pre > 0);
      if (p) begin
        for (int k = DEPTH - 1; k > 0; k--) m_stage[k] = m_stage[k-1];
        m_stage[0] = d;
      end
      if (p && !qq) begin
        if (pre == DEPTH) m_ovf = 1; else m_cnt = pre + 1;
      end else if (qq && !p) begin
        m_cnt = pre - 1;
      end
      m_unf = q && !p && (pre == 0);
    end
    m_err[1] = m_ovf | (m_err[1] & ~ec);
    m_err[0] = m_unf | (m_err[0] & ~ec);
  endtask

  task automatic check_all(input string tag);
    logic [511:0] exp_data;
    logic [511:0] exp_valid;
    logic [511:0] exp_pop;
    exp_data = '0;
    exp_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      exp_data[k*WIDTH +: WIDTH] = m_stage[k];
      if (k < m_cnt) exp_valid[k] = 1'b1;
    end
    exp_pop = '0;
    if (m_cnt > 0) exp_pop[WIDTH-1:0] = m_stage[m_cnt-1];
    check({tag, ".count"}, 512'(count_o), 512'(m_cnt));
    check({tag, ".valid"}, 512'(valid_o), exp_valid);
    check({tag, ".empty"}, 512'(empty_o), 512'(m_cnt == 0));
    check({tag, ".full"}, 512'(full_o), 512'(m_cnt == DEPTH));
    check({tag, ".ovf"}, 512'(overflow_o), 512'(m_ovf));
    check({tag, ".unf"}, 512'(underflow_o), 512'(m_unf));
    check({tag, ".pop_data"}, 512'(pop_data_o), exp_pop);
    check({tag, ".data"}, 512'(data_o), exp_data);
`ifdef SHIFT_FIFO_STICKY_ERR_EN
    check({tag, ".err"}, 512'(err_o), 512'(m_err));
`endif
  endtask

  // Drive one cycle of inputs, advance model and DUT, then compare.
  task automatic step(input string tag, input bit p, input bit q, input bit c,
                      input logic [WIDTH-1:0] d, input bit ec);
    push_i = p; pop_i = q; clear_i = c; data_i = d; err_clr_i = ec;
    @(posedge clk_i);
    model_edge(p, q, c, d, ec);
    #1;
    check_all(tag);
    push_i = 1'b0; pop_i = 1'b0; clear_i = 1'b0; err_clr_i = 1'b0;
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic do_reset(input string tag);
    #2;
    rst_i = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    bit p, q, c, ec;
    model_reset();
    #12;
    check_all("reset");
    rst_i = 1'b0;
    @(negedge clk_i);

    // Three pushes, then a single pop.
    step("pushA1", 1, 0, 0, 32'hA1, 0);
    step("pushA2", 1, 0, 0, 32'hA2, 0);
    step("pushA3", 1, 0, 0, 32'hA3, 0);
    check("tp.cnt3", 512'(count_o), 512'(3));
    check("tp.valid7", 512'(valid_o), 512'(16'h0007));
    check("tp.d0", 512'(data_o[0]), 512'(32'hA3));
    check("tp.d2", 512'(data_o[2]), 512'(32'hA1));
    check("tp.popA1", 512'(pop_data_o), 512'(32'hA1));
    step("pop1", 0, 1, 0, 32'h0, 0);
    check("tp.popA2", 512'(pop_data_o), 512'(32'hA2));

    // Fill past full: overflow on the 17th word.
    do_reset("rst_fill");
    for (int i = 1; i <= 17; i++) step("fill", 1, 0, 0, 32'(i), 0);
    check("tp.ovf", 512'(overflow_o), 512'(1));
    check("tp.cnt16", 512'(count_o), 512'(16));
    check("tp.d15", 512'(data_o[15]), 512'(32'd2));
    check("tp.pop2", 512'(pop_data_o), 512'(32'd2));
    step("ovf_idle", 0, 0, 0, 32'h0, 0);
    step("full_pushpop", 1, 1, 0, 32'h77, 0);

    // Underflow, then push+pop on empty.
    do_reset("rst_unf");
    step("unf", 0, 1, 0, 32'h0, 0);
    check("tp.unf", 512'(underflow_o), 512'(1));
    step("pp_empty", 1, 1, 0, 32'h55, 0);
    check("tp.pop55", 512'(pop_data_o), 512'(32'h55));

    // Clear with push at count 5.
    do_reset("rst_clr");
    for (int i = 0; i < 5; i++) step("pre_clr", 1, 0, 0, 32'h100 + 32'(i), 0);
    step("clear_push", 1, 0, 1, 32'hDEAD, 0);
    check("tp.clr_empty", 512'(empty_o), 512'(1));
    check("tp.clr_noshift", 512'(data_o[0]), 512'(32'h104));

    // Reset asserted mid-burst, then a fresh push.
    step("burst0", 1, 0, 0, 32'h1, 0);
    step("burst1", 1, 0, 0, 32'h2, 0);
    do_reset("rst_mid");
    step("after_rst", 1, 0, 0, 32'hBEEF, 0);

`ifdef SHIFT_FIFO_STICKY_ERR_EN
    do_reset("rst_err");
    for (int i = 0; i < DEPTH + 1; i++) step("err_fill", 1, 0, 0, 32'(i), 0);
    for (int i = 0; i < 3; i++) step("err_hold", 0, 0, 0, 32'h0, 0);
    check("tp.err10", 512'(err_o), 512'(2'b10));
    step("err_clrpop", 0, 0, 1, 32'h0, 0);
    step("err_clr_unf", 0, 1, 0, 32'h0, 1);
    check("tp.err01", 512'(err_o), 512'(2'b01));
`endif

    // Random traffic with occasional clears and sticky-clears.
    do_reset("rst_rand");
    for (int i = 0; i < 600; i++) begin
      p  = ($urandom_range(0, 99) < 55);
      q  = ($urandom_range(0, 99) < 40);
      c  = ($urandom_range(0, 99) < 3);
      ec = ($urandom_range(0, 99) < 5);
      step("rand", p, q, c, $urandom, ec);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
